// File: rtl/instr_queue_pkg.sv
// Shared payload type for the fetch-to-decode instruction queue.
package instr_queue_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_data_t;

endpackage

// File: rtl/instr_queue.sv
// Fetch-to-decode instruction queue: 2-wide push, 2-wide pop circular buffer.
// Optional same-cycle bypass when empty is enabled by defining IQ_BYPASS_EN.
module instr_queue
    import instr_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_finish,
    input  logic [1:0]            in_valid,
    input  fetch_data_t [1:0]     in_data,
    output logic                  full,
    output logic [1:0]            out_valid,
    output fetch_data_t [1:0]     out_data,
    input  logic [1:0]            out_pop,
    output logic [CW-1:0]         count,
    output logic                  overflow
);

    localparam int unsigned IW = CW - 1;
    localparam int unsigned FW = CW + 1;

    logic [CW-1:0] head;
    logic [CW-1:0] tail;
    logic          ovf_q;
    fetch_data_t   mem [DEPTH];

    logic [CW-1:0] count_c;
    logic [CW-1:0] head_n;
    logic [CW-1:0] tail_n;
    logic [IW-1:0] head_idx1;
    logic [IW-1:0] tail_idx1;
    logic [1:0]    push_n;
    logic [1:0]    pop_req;
    logic [1:0]    avail;
    logic [1:0]    pops;
    logic [1:0]    shift;
    logic [1:0]    nwr;
    logic [FW-1:0] free;
    logic          accept;
    logic          byp;
    fetch_data_t   entry0;
    fetch_data_t   entry1;
    fetch_data_t   wr_a;

    assign count_c   = tail - head;
    assign count     = count_c;
    assign full      = count_c >= CW'(DEPTH - 1);
    assign overflow  = ovf_q;
    assign head_idx1 = head[IW-1:0] + IW'(1);
    assign tail_idx1 = tail[IW-1:0] + IW'(1);

    // Pop is resolved before push; the push must then fit entirely or is dropped.
    always_comb begin
        pop_req = 2'd0;
        push_n  = 2'd0;
        avail   = 2'd0;
        pops    = 2'd0;
        shift   = 2'd0;
        nwr     = 2'd0;
        byp     = 1'b0;
        wr_a    = '0;

        case (out_pop)
            2'b01:   pop_req = 2'd1;
            2'b11:   pop_req = 2'd2;
            default: pop_req = 2'd0;
        endcase

        if (in_finish)
            push_n = 2'({1'b0, in_valid[0]} + {1'b0, in_valid[1]});

        entry0 = in_valid[0] ? in_data[0] : in_data[1];
        entry1 = in_data[1];

`ifdef IQ_BYPASS_EN
        byp = (count_c == '0);
`else
        byp = 1'b0;
`endif

        if (byp)
            avail = push_n;
        else if (count_c >= CW'(2))
            avail = 2'd2;
        else
            avail = count_c[1:0];

        pops   = (pop_req > avail) ? avail : pop_req;
        free   = FW'(DEPTH) - {1'b0, count_c} + FW'(pops);
        accept = FW'(push_n) <= free;

        // Bypassed entries consumed this cycle never reach storage.
        shift = byp ? pops : 2'd0;
        if (accept)
            nwr = push_n - shift;
        wr_a = (shift == 2'd0) ? entry0 : entry1;

        head_n = head + CW'(pops) - CW'(shift);
        tail_n = tail + CW'(nwr);
    end

    always_comb begin
        out_valid   = {count_c >= CW'(2), count_c != '0};
        out_data[0] = mem[head[IW-1:0]];
        out_data[1] = mem[head_idx1];
`ifdef IQ_BYPASS_EN
        if (byp) begin
            out_valid   = {push_n == 2'd2, push_n != 2'd0};
            out_data[0] = entry0;
            out_data[1] = entry1;
        end
        if (flush)
            out_valid = 2'b00;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            ovf_q <= 1'b0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
        end else begin
            head <= head_n;
            tail <= tail_n;
            if (push_n != 2'd0 && !accept)
                ovf_q <= 1'b1;
        end
    end

    // Payload storage carries no reset; validity comes from the pointers.
    always_ff @(posedge clk) begin
        if (!flush) begin
            if (nwr != 2'd0)
                mem[tail[IW-1:0]] <= wr_a;
            if (nwr == 2'd2)
                mem[tail_idx1] <= entry1;
        end
    end

endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue: directed table, corner sequences, random vs queue model.
module tb_instr_queue;
    import instr_queue_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              in_finish;
    logic [1:0]        in_valid;
    fetch_data_t [1:0] in_data;
    logic              full;
    logic [1:0]        out_valid;
    fetch_data_t [1:0] out_data;
    logic [1:0]        out_pop;
    logic [CW-1:0]     count;
    logic              overflow;

    int passed = 0;
    int total  = 0;

    logic [31:0] mq[$];
    logic        m_ovf;

    instr_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_finish(in_finish),
        .in_valid(in_valid), .in_data(in_data), .full(full),
        .out_valid(out_valid), .out_data(out_data), .out_pop(out_pop),
        .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fl;
        logic        fin;
        logic [1:0]  vld;
        logic [1:0]  pop;
        logic [31:0] pc0;
        logic [31:0] pc1;
        int          e_cnt;
        logic [1:0]  e_ov;
        logic [31:0] e_pc0;
        logic [31:0] e_pc1;
        logic        e_full;
        logic        e_ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference: plain FIFO of pcs; pops leave the front, then the whole push must fit.
    task automatic model_step(input logic fl, input logic fin, input logic [1:0] vld,
                              input logic [1:0] pop, input logic [31:0] pc0, input logic [31:0] pc1);
        logic [31:0] p[$];
        int n;
        if (fl) begin
            mq.delete();
            return;
        end
        n = (pop == 2'b01) ? 1 : (pop == 2'b11) ? 2 : 0;
        while (n > 0 && mq.size() > 0) begin
            void'(mq.pop_front());
            n--;
        end
        if (fin && vld[0]) p.push_back(pc0);
        if (fin && vld[1]) p.push_back(pc1);
        if (p.size() <= int'(DEPTH) - mq.size()) begin
            foreach (p[i]) mq.push_back(p[i]);
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    task automatic drive(input logic fl, input logic fin, input logic [1:0] vld,
                         input logic [1:0] pop, input logic [31:0] pc0, input logic [31:0] pc1);
        flush = fl; in_finish = fin; in_valid = vld; out_pop = pop;
        in_data[0].pc = pc0; in_data[0].instr = ~pc0;
        in_data[1].pc = pc1; in_data[1].instr = ~pc1;
        model_step(fl, fin, vld, pop, pc0, pc1);
        @(posedge clk);
        #1;
        flush = 1'b0; in_finish = 1'b0; in_valid = 2'b00; out_pop = 2'b00;
    endtask

    task automatic check_model(input string tag);
        int sz;
        sz = mq.size();
        check({tag, ".count"}, 32'(count), 32'(sz));
        check({tag, ".full"}, 32'(full), 32'((int'(DEPTH) - sz) < 2));
        check({tag, ".out_valid"}, 32'(out_valid), 32'({sz >= 2, sz >= 1}));
        check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        if (sz >= 1) begin
            check({tag, ".pc0"}, out_data[0].pc, mq[0]);
            check({tag, ".instr0"}, out_data[0].instr, ~mq[0]);
        end
        if (sz >= 2) check({tag, ".pc1"}, out_data[1].pc, mq[1]);
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b1;
        mq.delete();
        m_ovf = 1'b0;
        #1;
        check("reset.count", 32'(count), 32'd0);
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.full", 32'(full), 32'd0);
        check("reset.overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    vec_t vt[10];

    initial begin
        reset = 1'b0; flush = 1'b0; in_finish = 1'b0; in_valid = 2'b00; out_pop = 2'b00;
        in_data = '0; m_ovf = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        vt[0] = '{0, 1, 2'b11, 2'b00, 32'h8000_0000, 32'h8000_0004, 2, 2'b11, 32'h8000_0000, 32'h8000_0004, 0, 0};
        vt[1] = '{0, 0, 2'b00, 2'b11, 32'h0, 32'h0, 0, 2'b00, 32'h0, 32'h0, 0, 0};
        vt[2] = '{0, 1, 2'b10, 2'b00, 32'hdead_beef, 32'h8000_0004, 1, 2'b01, 32'h8000_0004, 32'h0, 0, 0};
        vt[3] = '{0, 0, 2'b11, 2'b00, 32'h100, 32'h104, 1, 2'b01, 32'h8000_0004, 32'h0, 0, 0};
        vt[4] = '{0, 1, 2'b01, 2'b01, 32'h108, 32'h10c, 1, 2'b01, 32'h108, 32'h0, 0, 0};
        vt[5] = '{0, 1, 2'b11, 2'b10, 32'h200, 32'h204, 3, 2'b11, 32'h108, 32'h200, 0, 0};
        vt[6] = '{0, 0, 2'b00, 2'b11, 32'h0, 32'h0, 1, 2'b01, 32'h204, 32'h0, 0, 0};
        vt[7] = '{0, 0, 2'b00, 2'b11, 32'h0, 32'h0, 0, 2'b00, 32'h0, 32'h0, 0, 0};
        vt[8] = '{0, 0, 2'b00, 2'b01, 32'h0, 32'h0, 0, 2'b00, 32'h0, 32'h0, 0, 0};
        vt[9] = '{1, 1, 2'b11, 2'b11, 32'h300, 32'h304, 0, 2'b00, 32'h0, 32'h0, 0, 0};

        foreach (vt[i]) begin
            drive(vt[i].fl, vt[i].fin, vt[i].vld, vt[i].pop, vt[i].pc0, vt[i].pc1);
            check($sformatf("vec%0d.count", i), 32'(count), 32'(vt[i].e_cnt));
            check($sformatf("vec%0d.out_valid", i), 32'(out_valid), 32'(vt[i].e_ov));
            check($sformatf("vec%0d.full", i), 32'(full), 32'(vt[i].e_full));
            check($sformatf("vec%0d.overflow", i), 32'(overflow), 32'(vt[i].e_ovf));
            if (vt[i].e_ov[0]) check($sformatf("vec%0d.pc0", i), out_data[0].pc, vt[i].e_pc0);
            if (vt[i].e_ov[1]) check($sformatf("vec%0d.pc1", i), out_data[1].pc, vt[i].e_pc1);
        end

        // Fill two per cycle to DEPTH, then one more push overflows.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            drive(0, 1, 2'b11, 2'b00, 32'h1000 + 32'(8 * k), 32'h1004 + 32'(8 * k));
            check_model($sformatf("fill%0d", k));
        end
        check("fill.count16", 32'(count), 32'd16);
        check("fill.full", 32'(full), 32'd1);
        drive(0, 1, 2'b11, 2'b00, 32'h2000, 32'h2004);
        check("ovf.count", 32'(count), 32'd16);
        check("ovf.flag", 32'(overflow), 32'd1);
        check_model("ovf");
        drive(1, 0, 2'b00, 2'b00, 32'h0, 32'h0);
        check("flush_keeps_ovf", 32'(overflow), 32'd1);
        check_model("flush_after_ovf");

        // count = DEPTH-1 with push 2 / pop 2 in the same cycle.
        do_reset();
        for (int k = 0; k < 7; k++) drive(0, 1, 2'b11, 2'b00, 32'h3000 + 32'(8 * k), 32'h3004 + 32'(8 * k));
        drive(0, 1, 2'b01, 2'b00, 32'h3100, 32'h0);
        check("c15.count", 32'(count), 32'd15);
        check("c15.full", 32'(full), 32'd1);
        drive(0, 1, 2'b11, 2'b11, 32'h3200, 32'h3204);
        check("c15.pp.count", 32'(count), 32'd15);
        check("c15.pp.overflow", 32'(overflow), 32'd0);
        check_model("c15.pp");

        // Pointer wrap under steady push 2 / pop 2.
        do_reset();
        for (int k = 0; k < 40; k++) begin
            drive(0, 1, 2'b11, 2'b11, 32'h4000 + 32'(8 * k), 32'h4004 + 32'(8 * k));
            check_model($sformatf("wrap%0d", k));
        end

        // Flush with simultaneous push and pop at count 6.
        do_reset();
        for (int k = 0; k < 3; k++) drive(0, 1, 2'b11, 2'b00, 32'h5000 + 32'(8 * k), 32'h5004 + 32'(8 * k));
        check("pre_flush.count", 32'(count), 32'd6);
        drive(1, 1, 2'b11, 2'b11, 32'h5100, 32'h5104);
        check("flush.count", 32'(count), 32'd0);
        check("flush.out_valid", 32'(out_valid), 32'd0);

        // Random traffic against the model, with a reset dropped in mid-stream.
        do_reset();
        for (int k = 0; k < 400; k++) begin
            logic        fl;
            logic        fin;
            logic [1:0]  vld;
            logic [1:0]  pop;
            fl  = ($urandom_range(0, 31) == 0);
            fin = ($urandom_range(0, 3) != 0);
            vld = 2'($urandom_range(0, 3));
            pop = 2'($urandom_range(0, 3));
            drive(fl, fin, vld, pop, 32'h9000_0000 + 32'(8 * k), 32'h9000_0004 + 32'(8 * k));
            check_model($sformatf("rnd%0d", k));
            if (k == 200) do_reset();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
